// File: rtl/mac_array_ctrl_pkg.sv
// Shared types and width helpers for the mac_array_ctrl matrix engine.
// Included by the top and by the mac_lane datapath.
package mac_array_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

   localparam int MIN_IDX_W = 1;

   function automatic int idx_w(input int n);
      return (n <= 2) ? MIN_IDX_W : $clog2(n);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int out_width(input int dw_in, input int k);
      return 2 * dw_in + $clog2(k) + 1;
   endfunction

endpackage

// File: rtl/mac_array_ctrl_lane.sv
// mac_lane: one signed/unsigned multiplier feeding a DW_OUT accumulator.
// Operands carry one extra sign bit so a single multiplier serves both modes.
module mac_lane
   import mac_array_pkg::*;
#(
   parameter int DW_IN  = 32,
   parameter int DW_OUT = out_width(32, 4)
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              clr,
   input  logic              preload,
   input  logic [DW_OUT-1:0] preload_val,
   input  logic              en,
   input  logic              signed_mode,
   input  logic [DW_IN-1:0]  a,
   input  logic [DW_IN-1:0]  b,
   output logic [DW_OUT-1:0] acc
);

   logic signed [DW_OUT-1:0] a_w;
   logic signed [DW_OUT-1:0] b_w;
   logic signed [DW_OUT-1:0] prod;
   logic [DW_OUT-1:0]        base;
   logic [DW_OUT-1:0]        acc_q;

   // Low DW_OUT bits of the extended product are exact modulo 2^DW_OUT
   assign a_w  = DW_OUT'($signed({signed_mode & a[DW_IN-1], a}));
   assign b_w  = DW_OUT'($signed({signed_mode & b[DW_IN-1], b}));
   assign prod = a_w * b_w;
   assign base = clr ? (preload ? preload_val : '0) : acc_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= base + prod;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: LANES-wide matrix multiply C = A*B with load port and C stream.
// Define MAC_ACCUM_EN to let acc_en accumulate into the existing C contents.
module mac_array_ctrl
   import mac_array_pkg::*;
#(
   parameter int M      = 4,
   parameter int K      = 4,
   parameter int N      = 4,
   parameter int LANES  = 2,
   parameter int DW_IN  = 32,
   parameter int DW_OUT = out_width(DW_IN, K),
   localparam int RW    = max2(idx_w(M), idx_w(K)),
   localparam int CW    = max2(idx_w(K), idx_w(N))
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              ld_val,
   output logic              ld_rdy,
   input  logic              ld_sel_b,
   input  logic [RW-1:0]     ld_row,
   input  logic [CW-1:0]     ld_col,
   input  logic [DW_IN-1:0]  ld_data,
   input  logic              ld_done,
   input  logic              start_val,
   output logic              start_rdy,
   input  logic              mode_signed,
   input  logic              acc_en,
   output logic              busy,
   output logic              mac_done,
   output logic              c_val,
   input  logic              c_rdy,
   output logic [DW_OUT-1:0] c_data,
   output logic              c_last
);

   localparam int NG  = N / LANES;
   localparam int IW  = idx_w(M);
   localparam int GW  = idx_w(NG);
   localparam int KW  = idx_w(K + 1);
   localparam int AW  = idx_w(M * K);
   localparam int BW  = idx_w(K * N);
   localparam int CAW = idx_w(M * N);
   localparam int XW  = idx_w(M * N + 1);

   if (N % LANES != 0) begin : g_bad_lanes
      $error("mac_array_ctrl: LANES must divide N");
   end

   state_t            state_q, state_d;
   logic [IW-1:0]     i_q, i_d;
   logic [GW-1:0]     g_q, g_d;
   logic [KW-1:0]     k_q, k_d;
   logic [XW-1:0]     idx_q, idx_d;
   logic              c_val_q, c_val_d;
   logic              c_last_q, c_last_d;
   logic [DW_OUT-1:0] c_data_q, c_data_d;
   logic              signed_q, signed_d;
   logic              acc_en_q, acc_en_d;

   logic [DW_IN-1:0]  a_q [M*K];
   logic [DW_IN-1:0]  b_q [K*N];
   logic [DW_OUT-1:0] c_q [M*N];

   logic [DW_IN-1:0]  a_op;
   logic [DW_IN-1:0]  b_op    [LANES];
   logic [DW_OUT-1:0] acc     [LANES];
   logic [DW_OUT-1:0] pre_val [LANES];
   logic [CAW-1:0]    c_addr  [LANES];
   logic              lane_en, lane_clr, wb, preload;
   logic              we_a, we_b;

   assign ld_rdy    = state_q == LOAD;
   assign start_rdy = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign c_val     = c_val_q;
   assign c_last    = c_last_q;
   assign c_data    = c_data_q;

   // k_q == K marks the writeback beat that closes each column group
   assign lane_en  = (state_q == COMPUTE) && (k_q != KW'(K));
   assign wb       = (state_q == COMPUTE) && (k_q == KW'(K));
   assign lane_clr = k_q == '0;
   assign mac_done = wb && (i_q == IW'(M - 1)) && (g_q == GW'(NG - 1));
   assign a_op     = a_q[AW'(i_q * K + k_q)];

   assign we_a = ld_val && ld_rdy && !ld_sel_b
              && (int'(ld_row) < M) && (int'(ld_col) < K);
   assign we_b = ld_val && ld_rdy && ld_sel_b
              && (int'(ld_row) < K) && (int'(ld_col) < N);

`ifdef MAC_ACCUM_EN
   assign preload = acc_en_q;
`else
   logic unused_acc_en;
   assign unused_acc_en = acc_en_q;
   assign preload = 1'b0;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign c_addr[l]  = CAW'(i_q * N + g_q * LANES + l);
      assign b_op[l]    = b_q[BW'(k_q * N + g_q * LANES + l)];
      assign pre_val[l] = c_q[c_addr[l]];

      mac_lane #(
         .DW_IN  (DW_IN),
         .DW_OUT (DW_OUT)
      ) u_lane (
         .clk         (clk),
         .resetn      (resetn),
         .clr         (lane_clr),
         .preload     (preload),
         .preload_val (pre_val[l]),
         .en          (lane_en),
         .signed_mode (signed_q),
         .a           (a_op),
         .b           (b_op[l]),
         .acc         (acc[l])
      );
   end

   always_ff @(posedge clk) begin
      if (we_a) a_q[AW'(ld_row * K + ld_col)] <= ld_data;
      if (we_b) b_q[BW'(ld_row * N + ld_col)] <= ld_data;
      if (wb) begin
         for (int l = 0; l < LANES; l++) c_q[c_addr[l]] <= acc[l];
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      g_d      = g_q;
      k_d      = k_q;
      idx_d    = idx_q;
      c_val_d  = c_val_q;
      c_last_d = c_last_q;
      c_data_d = c_data_q;
      signed_d = signed_q;
      acc_en_d = acc_en_q;
      unique case (state_q)
         IDLE: begin
            if (start_val) begin
               state_d  = LOAD;
               signed_d = mode_signed;
               acc_en_d = acc_en;
               idx_d    = '0;
            end
         end
         LOAD: begin
            if (ld_done) begin
               state_d = COMPUTE;
               i_d     = '0;
               g_d     = '0;
               k_d     = '0;
            end
         end
         COMPUTE: begin
            if (!wb) begin
               k_d = k_q + 1'b1;
            end else begin
               k_d = '0;
               if (g_q != GW'(NG - 1)) begin
                  g_d = g_q + 1'b1;
               end else begin
                  g_d = '0;
                  if (i_q != IW'(M - 1)) begin
                     i_d = i_q + 1'b1;
                  end else begin
                     i_d     = '0;
                     idx_d   = '0;
                     state_d = DRAIN;
                  end
               end
            end
         end
         DRAIN: begin
            // Output register refills whenever empty or consumed
            if (!c_val_q || c_rdy) begin
               if (c_val_q && c_last_q) begin
                  state_d  = IDLE;
                  c_val_d  = 1'b0;
                  c_last_d = 1'b0;
                  idx_d    = '0;
               end else begin
                  c_data_d = c_q[CAW'(idx_q)];
                  c_val_d  = 1'b1;
                  c_last_d = idx_q == XW'(M * N - 1);
                  idx_d    = idx_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         i_q      <= '0;
         g_q      <= '0;
         k_q      <= '0;
         idx_q    <= '0;
         c_val_q  <= 1'b0;
         c_last_q <= 1'b0;
         c_data_q <= '0;
         signed_q <= 1'b0;
         acc_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         g_q      <= g_d;
         k_q      <= k_d;
         idx_q    <= idx_d;
         c_val_q  <= c_val_d;
         c_last_q <= c_last_d;
         c_data_q <= c_data_d;
         signed_q <= signed_d;
         acc_en_q <= acc_en_d;
      end
   end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl (M=K=N=4, LANES=2, DW_IN=8).
// Reference C is computed from plain integer matrix arithmetic.
module tb_mac_array_ctrl;

   localparam int M      = 4;
   localparam int K      = 4;
   localparam int N      = 4;
   localparam int NE     = M * N;
   localparam int DW_OUT = 19;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              ld_val = 1'b0;
   logic              ld_rdy;
   logic              ld_sel_b = 1'b0;
   logic [1:0]        ld_row = '0;
   logic [1:0]        ld_col = '0;
   logic [7:0]        ld_data = '0;
   logic              ld_done = 1'b0;
   logic              start_val = 1'b0;
   logic              start_rdy;
   logic              mode_signed = 1'b0;
   logic              acc_en = 1'b0;
   logic              busy;
   logic              mac_done;
   logic              c_val;
   logic              c_rdy = 1'b0;
   logic [DW_OUT-1:0] c_data;
   logic              c_last;

   int                n_vec = 0;
   int                n_err = 0;
   logic [7:0]        ma [16];
   logic [7:0]        mb [16];
   logic [DW_OUT-1:0] exp_c  [16];
   logic [DW_OUT-1:0] prev_c [16];
   int                rx = 0;
   bit                mon_en = 1'b0;
   bit                stall = 1'b0;
   logic [DW_OUT-1:0] stall_d;
   logic              stall_l;

   always #5 clk = ~clk;

   mac_array_ctrl #(
      .M(M), .K(K), .N(N), .LANES(2), .DW_IN(8)
   ) dut (
      .clk(clk), .resetn(resetn),
      .ld_val(ld_val), .ld_rdy(ld_rdy), .ld_sel_b(ld_sel_b),
      .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data),
      .ld_done(ld_done), .start_val(start_val), .start_rdy(start_rdy),
      .mode_signed(mode_signed), .acc_en(acc_en), .busy(busy),
      .mac_done(mac_done), .c_val(c_val), .c_rdy(c_rdy),
      .c_data(c_data), .c_last(c_last)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, want);
      end
   endtask

   task automatic slot();
      @(posedge clk);
      #1;
   endtask

   task automatic model(input bit sgn, input bit accum);
      bit use_prev;
      use_prev = accum;
`ifndef MAC_ACCUM_EN
      use_prev = 1'b0;
`endif
      for (int r = 0; r < M; r++) begin
         for (int c = 0; c < N; c++) begin
            longint s;
            longint x;
            longint y;
            s = use_prev ? longint'(prev_c[r*N+c]) : 0;
            for (int k = 0; k < K; k++) begin
               x = sgn ? longint'($signed(ma[r*K+k])) : longint'(ma[r*K+k]);
               y = sgn ? longint'($signed(mb[k*N+c])) : longint'(mb[k*N+c]);
               s = s + x * y;
            end
            exp_c[r*N+c] = s[DW_OUT-1:0];
         end
      end
   endtask

   task automatic set_identity();
      for (int i = 0; i < 16; i++) begin
         ma[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
         mb[i] = 8'(i);
      end
   endtask

   task automatic set_random();
      for (int i = 0; i < 16; i++) begin
         ma[i] = 8'($urandom);
         mb[i] = 8'($urandom);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      slot();
      resetn = 1'b1;
      slot();
   endtask

   // Handshakes are visible at the negedge before the consuming posedge
   always @(negedge clk) begin
      if (!resetn || !mon_en) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("hold_val", c_val, 1);
            chk("hold_data", c_data, stall_d);
            chk("hold_last", c_last, stall_l);
         end
         if (c_val && c_rdy) begin
            if (rx < NE) begin
               chk("c_data", c_data, exp_c[rx]);
               chk("c_last", c_last, rx == NE - 1);
            end else begin
               chk("extra_elem", rx, NE - 1);
            end
            rx++;
         end
         stall   = c_val && !c_rdy;
         stall_d = c_data;
         stall_l = c_last;
      end
   end

   task automatic run_job(input bit sgn, input bit accum, input int rdy_mode,
                          input bit poke, input int rst_at);
      int w;
      int done_at;
      w = 0;
      while (!start_rdy && w < 100) begin
         slot();
         w++;
      end
      chk("start_rdy_idle", start_rdy, 1);
      start_val   = 1'b1;
      mode_signed = sgn;
      acc_en      = accum;
      slot();
      chk("ld_rdy_load", ld_rdy, 1);
      chk("busy_load", busy, 1);
      chk("start_rdy_load", start_rdy, 0);
      start_val   = 1'b0;
      mode_signed = 1'($urandom);
      acc_en      = 1'($urandom);
      for (int e = 0; e < 32; e++) begin
         if ($urandom_range(3) == 0) begin
            ld_val  = 1'b0;
            ld_data = 8'($urandom);
            slot();
         end
         ld_val   = 1'b1;
         ld_sel_b = e >= 16;
         ld_row   = 2'((e % 16) / 4);
         ld_col   = 2'(e % 4);
         ld_data  = (e < 16) ? ma[e] : mb[e-16];
         ld_done  = e == 31;
         slot();
      end
      ld_val  = 1'b0;
      ld_done = 1'b0;
      model(sgn, accum);
      done_at = 0;
      for (int cyc = 1; cyc <= 200 && done_at == 0; cyc++) begin
         if (rst_at == cyc) begin
            resetn = 1'b0;
            #1;
            chk("rst_start_rdy", start_rdy, 1);
            chk("rst_busy", busy, 0);
            chk("rst_c_val", c_val, 0);
            chk("rst_ld_rdy", ld_rdy, 0);
            slot();
            resetn = 1'b1;
            return;
         end
         if (mac_done) begin
            done_at = cyc;
         end else begin
            if (poke && cyc == 5) begin
               ld_val   = 1'b1;
               ld_sel_b = 1'b0;
               ld_row   = 2'd0;
               ld_col   = 2'd0;
               ld_data  = ~ma[0];
               ld_done  = 1'b1;
               start_val = 1'b1;
            end else if (poke && cyc == 6) begin
               chk("ld_rdy_compute", ld_rdy, 0);
               chk("busy_compute", busy, 1);
               ld_val    = 1'b0;
               ld_done   = 1'b0;
               start_val = 1'b0;
            end
            slot();
         end
      end
      chk("mac_done_cycle", done_at, 40);
      if (done_at == 0) begin
         do_reset();
         return;
      end
      slot();
      chk("drain_first_idle", c_val, 0);
      chk("busy_drain", busy, 1);
      rx     = 0;
      mon_en = 1'b1;
      for (w = 0; w < 400 && rx < NE; w++) begin
         c_rdy = (rdy_mode == 0) ? 1'b1 :
                 (rdy_mode == 1) ? 1'(w % 2) : 1'($urandom_range(1));
         start_val = poke && w == 3;
         ld_val    = poke && w == 3;
         slot();
         if (w == 0) chk("first_c_val", c_val, 1);
         if (poke && w == 3) begin
            chk("start_ign_busy", busy, 1);
            chk("start_ign_rdy", start_rdy, 0);
            chk("ld_ign_rdy", ld_rdy, 0);
         end
      end
      start_val = 1'b0;
      ld_val    = 1'b0;
      chk("drained_all", rx, NE);
      chk("idle_start_rdy", start_rdy, 1);
      chk("idle_busy", busy, 0);
      chk("idle_c_val", c_val, 0);
      mon_en = 1'b0;
      c_rdy  = 1'b0;
      prev_c = exp_c;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_start_rdy", start_rdy, 1);
      chk("reset_ld_rdy", ld_rdy, 0);
      chk("reset_busy", busy, 0);
      chk("reset_mac_done", mac_done, 0);
      chk("reset_c_val", c_val, 0);
      chk("reset_c_last", c_last, 0);
      chk("reset_c_data", c_data, 0);
      resetn = 1'b1;
      slot();

      set_identity();
      model(1'b0, 1'b0);
      chk("model_id_5", exp_c[5], 5);
      chk("model_id_15", exp_c[15], 15);
      run_job(1'b0, 1'b0, 0, 1'b0, 0);

      for (int i = 0; i < 16; i++) begin
         ma[i] = 8'hFF;
         mb[i] = 8'h02;
      end
      model(1'b1, 1'b0);
      chk("model_neg8", exp_c[0], 19'h7FFF8);
      run_job(1'b1, 1'b0, 1, 1'b0, 0);
      model(1'b0, 1'b0);
      chk("model_2040", exp_c[7], 2040);
      run_job(1'b0, 1'b0, 1, 1'b0, 0);

      set_random();
      run_job(1'($urandom), 1'b0, 2, 1'b1, 0);

      set_random();
      run_job(1'b0, 1'b0, 0, 1'b0, 10);
      set_random();
      run_job(1'b1, 1'b0, 2, 1'b0, 0);

      repeat (5) begin
         set_random();
         run_job(1'($urandom), 1'b0, int'($urandom_range(2)), 1'b0, 0);
      end

`ifdef MAC_ACCUM_EN
      set_identity();
      run_job(1'b0, 1'b0, 0, 1'b0, 0);
      run_job(1'b0, 1'b1, 2, 1'b0, 0);
      chk("accum_pin", exp_c[6], 12);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
